// File: rtl/countdown_timer.sv
// Countdown timer: loadable down-counter with prescaler, one-shot/periodic
// modes, a one-cycle expiry pulse and a sticky interrupt flag.
module countdown_timer #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_i,
  input  logic [WIDTH-1:0]          loadValue_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      periodic_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  input  logic                      irq_clr_i,
  output logic [WIDTH-1:0]          count_o,
  output logic                      running_o,
  output logic                      expired_o,
  output logic                      irq_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]                state_r,   state_nx;
  logic [WIDTH-1:0]          count_r,   count_nx;
  logic [WIDTH-1:0]          reload_r,  reload_nx;
  logic [PRESCALE_WIDTH-1:0] pscnt_r,   pscnt_nx;
  logic                      expired_r, expired_nx;
  logic                      irq_r,     irq_nx;
  logic                      tick;
  logic                      expiry;

  // State and datapath registers; reset is immediate and clock-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      count_r   <= '0;
      reload_r  <= '0;
      pscnt_r   <= '0;
      expired_r <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      state_r   <= state_nx;
      count_r   <= count_nx;
      reload_r  <= reload_nx;
      pscnt_r   <= pscnt_nx;
      expired_r <= expired_nx;
      irq_r     <= irq_nx;
    end
  end

  // Next-state and datapath logic; command priority is load > stop > start.
  always_comb begin
    state_nx  = state_r;
    count_nx  = count_r;
    reload_nx = reload_r;
    pscnt_nx  = pscnt_r;

    // A stop in RUN freezes the prescaler, so it also suppresses the tick.
    tick       = (state_r == ST_RUN) && !stop_i && (pscnt_r >= prescale_i);
    expiry     = tick && (count_r == WIDTH'(1));
    expired_nx = expiry;
    irq_nx     = expiry ? 1'b1 : (irq_clr_i ? 1'b0 : irq_r);

    if (load_i) begin
      count_nx  = loadValue_i;
      reload_nx = loadValue_i;
      pscnt_nx  = '0;
      if (stop_i) begin
        state_nx = ST_IDLE;
      end else if (start_i || (state_r == ST_RUN)) begin
        // Running with a zero count would never expire, so park in IDLE.
        state_nx = (loadValue_i != '0) ? ST_RUN : ST_IDLE;
      end else begin
        state_nx = ST_IDLE;
      end
    end else begin
      case (state_r)
        ST_RUN: begin
          if (stop_i) begin
            state_nx = ST_IDLE;
          end else if (tick) begin
            pscnt_nx = '0;
            if (count_r > WIDTH'(1)) begin
              count_nx = count_r - WIDTH'(1);
            end else if (count_r == WIDTH'(1)) begin
              if (periodic_i && (reload_r != '0)) begin
                count_nx = reload_r;
              end else begin
                count_nx = '0;
                state_nx = ST_DONE;
              end
            end
          end else begin
            pscnt_nx = pscnt_r + PRESCALE_WIDTH'(1);
          end
        end
        ST_IDLE, ST_DONE: begin
          if (start_i && !stop_i && (count_r != '0)) begin
            state_nx = ST_RUN;
            pscnt_nx = '0;
          end
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // Output mapping; running_o decodes the state register directly.
  assign count_o   = count_r;
  assign running_o = (state_r == ST_RUN);
  assign expired_o = expired_r;
  assign irq_o     = irq_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random
// traffic, compared every cycle against a behavioural model.
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_i;
  logic [31:0] loadValue_i;
  logic        start_i;
  logic        stop_i;
  logic        periodic_i;
  logic [7:0]  prescale_i;
  logic        irq_clr_i;
  logic [31:0] count_o;
  logic        running_o;
  logic        expired_o;
  logic        irq_o;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: mode 0 = stopped, 1 = counting, 2 = finished.
  int          m_mode;
  logic [31:0] m_count;
  logic [31:0] m_reload;
  int          m_psc;
  bit          m_exp;
  bit          m_irq;

  countdown_timer #(.WIDTH(32), .PRESCALE_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load_i),
    .loadValue_i (loadValue_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .periodic_i  (periodic_i),
    .prescale_i  (prescale_i),
    .irq_clr_i   (irq_clr_i),
    .count_o     (count_o),
    .running_o   (running_o),
    .expired_o   (expired_o),
    .irq_o       (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_count = 0; m_reload = 0; m_psc = 0; m_exp = 0; m_irq = 0;
  endtask

  // One clock: predict from pre-edge inputs, clock, compare, drop pulse commands.
  task automatic cyc();
    int          n_mode  = m_mode;
    logic [31:0] n_count = m_count;
    logic [31:0] n_rel   = m_reload;
    int          n_psc   = m_psc;
    bit          tk;
    tk    = (m_mode == 1) && !stop_i && (m_psc >= int'(prescale_i));
    m_exp = tk && (m_count == 32'd1);
    if (m_exp) m_irq = 1;
    else if (irq_clr_i) m_irq = 0;
    if (load_i) begin
      n_count = loadValue_i; n_rel = loadValue_i; n_psc = 0;
      if (stop_i) n_mode = 0;
      else if (start_i || m_mode == 1) n_mode = (loadValue_i != 0) ? 1 : 0;
      else n_mode = 0;
    end else if (m_mode == 1) begin
      if (stop_i) n_mode = 0;
      else if (tk) begin
        n_psc = 0;
        if (m_count > 1) n_count = m_count - 1;
        else if (m_count == 1) begin
          if (periodic_i && m_reload != 0) n_count = m_reload;
          else begin n_count = 0; n_mode = 2; end
        end
      end else n_psc = m_psc + 1;
    end else if (start_i && !stop_i && m_count != 0) begin
      n_mode = 1; n_psc = 0;
    end
    @(posedge clk);
    m_mode = n_mode; m_count = n_count; m_reload = n_rel; m_psc = n_psc;
    #1;
    chk("model_count",   count_o,          m_count);
    chk("model_running", 32'(running_o),   32'(m_mode == 1));
    chk("model_expired", 32'(expired_o),   32'(m_exp));
    chk("model_irq",     32'(irq_o),       32'(m_irq));
    load_i = 0; start_i = 0; stop_i = 0; irq_clr_i = 0;
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_count"},   count_o,        32'd0);
    chk({tag, "_running"}, 32'(running_o), 32'd0);
    chk({tag, "_expired"}, 32'(expired_o), 32'd0);
    chk({tag, "_irq"},     32'(irq_o),     32'd0);
  endtask

  initial begin
    rst_n = 0; load_i = 0; loadValue_i = 0; start_i = 0; stop_i = 0;
    periodic_i = 0; prescale_i = 0; irq_clr_i = 0;
    model_reset();
    #2;
    outs_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    cyc();

    // Load 3, start, one-shot, prescale 0: 3,2,1,0 on consecutive edges.
    loadValue_i = 3; load_i = 1; start_i = 1;
    cyc(); chk("os_c3", count_o, 32'd3); chk("os_run", 32'(running_o), 32'd1);
    cyc(); chk("os_c2", count_o, 32'd2);
    cyc(); chk("os_c1", count_o, 32'd1); chk("os_noexp", 32'(expired_o), 32'd0);
    cyc(); chk("os_c0", count_o, 32'd0); chk("os_exp", 32'(expired_o), 32'd1);
    chk("os_done", 32'(running_o), 32'd0); chk("os_irq", 32'(irq_o), 32'd1);
    cyc(); chk("os_exp_1cyc", 32'(expired_o), 32'd0); chk("os_irq_sticky", 32'(irq_o), 32'd1);

    // Load 2, prescale 3, periodic: 2,1,2,1 every 4 clocks, pulse every 8.
    irq_clr_i = 1; cyc();
    periodic_i = 1; prescale_i = 3; loadValue_i = 2; load_i = 1; start_i = 1;
    cyc();
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk("per_count",   count_o,          ((k / 4) % 2 == 0) ? 32'd2 : 32'd1);
      chk("per_expired", 32'(expired_o),   32'((k % 8) == 0));
      chk("per_running", 32'(running_o),   32'd1);
    end

    // Stop at 5, hold, resume after prescale+1 clocks, start with 0 ignored.
    periodic_i = 0; prescale_i = 1; loadValue_i = 8; load_i = 1; start_i = 1;
    cyc();
    repeat (6) cyc();
    chk("sr_at5", count_o, 32'd5);
    stop_i = 1; cyc();
    chk("sr_stopped", 32'(running_o), 32'd0); chk("sr_held", count_o, 32'd5);
    repeat (3) cyc();
    chk("sr_still5", count_o, 32'd5);
    start_i = 1; cyc();
    chk("sr_resume_run", 32'(running_o), 32'd1); chk("sr_resume5", count_o, 32'd5);
    cyc(); chk("sr_wait", count_o, 32'd5);
    cyc(); chk("sr_dec4", count_o, 32'd4);
    stop_i = 1; cyc();
    loadValue_i = 0; load_i = 1; cyc();
    start_i = 1; cyc();
    chk("sr_zero_idle", 32'(running_o), 32'd0); chk("sr_zero_cnt", count_o, 32'd0);

    // irq_clr on the expiry tick loses to the set; alone it clears.
    prescale_i = 0; loadValue_i = 1; load_i = 1; start_i = 1;
    cyc();
    irq_clr_i = 1; cyc();
    chk("irq_set_wins", 32'(irq_o), 32'd1); chk("irq_exp", 32'(expired_o), 32'd1);
    irq_clr_i = 1; cyc();
    chk("irq_cleared", 32'(irq_o), 32'd0);

    // Full-scale load wraps nothing; zero load with start stays idle.
    loadValue_i = 32'hFFFF_FFFF; load_i = 1; start_i = 1;
    cyc(); chk("max_load", count_o, 32'hFFFF_FFFF); chk("max_run", 32'(running_o), 32'd1);
    cyc(); chk("max_dec", count_o, 32'hFFFF_FFFE);
    loadValue_i = 0; load_i = 1; start_i = 1;
    cyc(); chk("zero_idle", 32'(running_o), 32'd0); chk("zero_cnt", count_o, 32'd0);
    cyc(); chk("zero_nopulse", 32'(expired_o), 32'd0);

    // Asynchronous reset mid-RUN between edges.
    loadValue_i = 10; load_i = 1; start_i = 1;
    cyc(); cyc();
    #2; rst_n = 0; #1;
    model_reset();
    outs_zero("arst");
    @(posedge clk); #1;
    outs_zero("arst_hold");
    @(negedge clk); rst_n = 1;
    loadValue_i = 1; load_i = 1; start_i = 1;
    cyc(); chk("post_rst_load", count_o, 32'd1); chk("post_rst_run", 32'(running_o), 32'd1);
    cyc(); chk("post_rst_exp", 32'(expired_o), 32'd1); chk("post_rst_c0", count_o, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      load_i      = ($urandom_range(0, 19) == 0);
      loadValue_i = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 6));
      start_i     = ($urandom_range(0, 4) == 0);
      stop_i      = ($urandom_range(0, 19) == 0);
      periodic_i  = $urandom_range(0, 1) == 1;
      prescale_i  = 8'($urandom_range(0, 3));
      irq_clr_i   = ($urandom_range(0, 9) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the count and load-value width in bits.
REQ-002 The block SHALL have parameter PRESCALE_WIDTH, default 8, giving the prescale-select width in bits.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, listed first among the ports below.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 load_i  input  1  load count and reload registers from loadValue_i.
REQ-007 loadValue_i  input  WIDTH  value to load.
REQ-008 start_i  input  1  request to begin or resume counting.
REQ-009 stop_i  input  1  request to pause counting.
REQ-010 periodic_i  input  1  1 = auto-reload on expiry; 0 = one-shot; sampled on the expiry tick.
REQ-011 prescale_i  input  PRESCALE_WIDTH  count tick every prescale_i+1 clocks.
REQ-012 irq_clr_i  input  1  clears irq_o.
REQ-013 count_o  output  WIDTH  current count register.
REQ-014 running_o  output  1  high in state RUN.
REQ-015 expired_o  output  1  one-cycle expiry pulse.
REQ-016 irq_o  output  1  sticky expiry flag.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-018 The block SHALL have internal registers reload_r[WIDTH] and pscnt_r[PRESCALE_WIDTH].
REQ-019 Command priority SHALL be load_i > stop_i > start_i, evaluated every cycle.
REQ-020 load_i in any state SHALL set count_r <= loadValue_i, reload_r <= loadValue_i and pscnt_r <= 0.
REQ-021 load_i in DONE SHALL move the FSM to IDLE.
REQ-022 load_i with start_i and without stop_i SHALL enter RUN if loadValue_i != 0, else IDLE.
REQ-023 load_i with stop_i SHALL leave the FSM in IDLE, or in RUN->IDLE.
REQ-024 stop_i in RUN SHALL move the FSM to IDLE with count_r held and pscnt_r held.
REQ-025 stop_i in IDLE or DONE SHALL have no effect.
REQ-026 start_i in IDLE or DONE SHALL enter RUN when count_r != 0, with pscnt_r <= 0; it SHALL be ignored when count_r == 0.
REQ-027 start_i in RUN SHALL have no effect.
REQ-028 In RUN, a tick SHALL occur in any cycle where pscnt_r >= prescale_i; pscnt_r <= 0 on a tick, else pscnt_r <= pscnt_r + 1.
REQ-029 With prescale_i = 0, a tick SHALL occur every cycle.
REQ-030 On a tick with count_r > 1, the block SHALL set count_r <= count_r - 1.
REQ-031 On a tick with count_r == 1 (expiry tick), the block SHALL register expired_o = 1 for the following cycle only, and SHALL set irq_o.
REQ-032 On an expiry tick with periodic_i = 1 and reload_r != 0, the block SHALL set count_r <= reload_r and remain in RUN; count_o SHALL never show 0.
REQ-033 On an expiry tick with periodic_i = 0, or with reload_r == 0, the block SHALL set count_r <= 0 and enter DONE.
REQ-034 Count arithmetic SHALL be unsigned modulo 2^WIDTH, and count_r SHALL never decrement below 0.
REQ-035 irq_o SHALL set on an expiry tick and clear on irq_clr_i; on the same cycle, set SHALL win.
REQ-036 A load_i on the same cycle as an expiry tick SHALL take priority: the loaded value applies, and expired_o/irq_o still assert.
REQ-037 running_o SHALL be combinational from the state register (state == RUN); all other outputs SHALL be registered.
REQ-038 Latency SHALL be: start_i at edge N -> running_o = 1 after edge N; first decrement at edge N+1+prescale_i.

Reset
REQ-039 rst_n = 0 SHALL immediately, without a clock, force state to IDLE, count_r = 0, reload_r = 0, pscnt_r = 0, expired_o = 0 and irq_o = 0.
REQ-040 While rst_n = 0, running_o SHALL read 0.
REQ-041 Reset assertion mid-RUN SHALL abort the countdown with no expired_o pulse.
REQ-042 After rst_n deasserts, all inputs SHALL be honoured from the first rising clk edge.

Verification
REQ-043 The bench SHALL cover: load 3, start, prescale 0, one-shot -> count 3,2,1,0 on consecutive edges; expired_o high exactly one cycle; DONE; irq_o = 1.
REQ-044 The bench SHALL cover: load 2, prescale 3, periodic -> decrement every 4 clocks; sequence 2,1,2,1,...; expired_o every 8 clocks; running_o stays 1.
REQ-045 The bench SHALL cover: running at count 5, stop_i -> IDLE, count held at 5; start_i -> resumes 4 after prescale_i+1 clocks; start_i with count 0 -> stays IDLE.
REQ-046 The bench SHALL cover: irq_clr_i on the same cycle as the expiry tick -> irq_o = 1; irq_clr_i alone one cycle later -> irq_o = 0.
REQ-047 The bench SHALL cover: load 0xFFFFFFFF with start -> RUN, first tick gives 0xFFFFFFFE; load 0 with start -> IDLE, no pulse.
REQ-048 The bench SHALL cover: rst_n low mid-RUN between clock edges -> outputs 0 immediately; no expired_o; after release, load 1 + start -> expiry on the next tick.
